// File: rtl/demux16_deser.sv
// demux16_deser
//   Serial-to-parallel collector, the receiving end of a mux16_1-style
//   serializer. Accepted bits are steered by a 4-bit index through a 1:16
//   one-hot write decode into a shadow word. When the last bit arrives, the
//   completed word moves to an output register. It is then offered under a
//   valid/ready handshake.
//
// Ports
//   clk        in   clock, all state changes on posedge
//   reset      in   synchronous active-low reset, overrides everything
//   flush      in   synchronous abort of the partial word in progress
//   in_valid   in   in_bit is valid this cycle
//   in_bit     in   serial data bit
//   in_ready   out  block can accept in_bit this cycle
//   out_valid  out  out_data holds a completed word
//   out_ready  in   consumer takes out_data this cycle
//   out_data   out  completed word [WIDTH-1:0]
//   fill       out  bits collected in the current partial word [IDX_W-1:0]
module demux16_deser #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] fill
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic             w_last;
  logic             w_accept;
  logic             w_take;
  logic [IDX_W-1:0] w_pos;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_merged;

  assign w_last   = (r_idx == LAST_IDX);
  // Stall only the final bit while the output slot is still occupied.
  // This depends on registered state only, so there is no path from out_ready.
  assign in_ready = ~(r_out_valid & w_last);
  assign w_accept = in_valid & in_ready;
  assign w_take   = r_out_valid & out_ready;

  assign w_pos = (MSB_FIRST != 0) ? (LAST_IDX - r_idx) : r_idx;

  // 1:WIDTH one-hot write decode
  always_comb begin
    w_dec = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      w_dec[k] = (w_pos == IDX_W'(k));
    end
  end

  // The shadow word with only the selected bit replaced. This is also the
  // completed word when the last bit arrives, so that bit lands in the same
  // cycle.
  assign w_merged = (r_shadow & ~w_dec) | (w_dec & {WIDTH{in_bit}});

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx       <= '0;
      r_shadow    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_take) begin
        r_out_valid <= 1'b0;
      end
      if (flush) begin
        r_idx    <= '0;
        r_shadow <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          // A completion can never coincide with a take, because in_ready is
          // low there. So this set of out_valid never races the clear above.
          r_out_data  <= w_merged;
          r_out_valid <= 1'b1;
          r_idx       <= '0;
          r_shadow    <= '0;
        end else begin
          r_shadow <= w_merged;
          r_idx    <= r_idx + 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign fill      = r_idx;

endmodule

// File: tb/tb_demux16_deser.sv
module tb_demux16_deser;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // LSB-first instance
  logic        reset, flush, in_valid, in_bit, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [3:0]  fill;

  // MSB-first instance
  logic        m_reset, m_flush, m_in_valid, m_in_bit, m_out_ready;
  logic        m_in_ready, m_out_valid;
  logic [15:0] m_out_data;
  logic [3:0]  m_fill;

  demux16_deser #(.WIDTH(16), .IDX_W(4), .MSB_FIRST(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_bit(in_bit), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fill(fill)
  );

  demux16_deser #(.WIDTH(16), .IDX_W(4), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(m_reset), .flush(m_flush), .in_valid(m_in_valid),
    .in_bit(m_in_bit), .in_ready(m_in_ready), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_data(m_out_data), .fill(m_fill)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        ib;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_fill;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv, input logic ib,
                     input logic ordy, input logic e_rdy, input logic e_ov,
                     input logic [15:0] e_od, input logic [3:0] e_fill);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ib = ib; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_fill = e_fill;
    vecs.push_back(v);
  endtask

  // First n bits of w, LSB first, starting from fill=0 with the output slot
  // in state (ov, od) and nobody taking it.
  task automatic add_bits(input logic [15:0] w, input int n, input logic ov, input logic [15:0] od);
    for (int i = 0; i < n; i++)
      add(1, 0, 1, w[i], 0, !(ov && (i + 1) == 15), ov, od, 4'(i + 1));
  endtask

  // A whole word LSB first, starting from fill=0 with the output slot empty.
  task automatic add_word(input logic [15:0] w, input logic ordy, input logic [15:0] od);
    for (int i = 0; i < 15; i++)
      add(1, 0, 1, w[i], ordy, 1, 0, od, 4'(i + 1));
    add(1, 0, 1, w[15], ordy, 1, 1, w, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; flush = 0; in_valid = 0; in_bit = 0; out_ready = 0;
    m_reset = 0; m_flush = 0; m_in_valid = 0; m_in_bit = 0; m_out_ready = 0;

    // Reset held for two cycles with in_valid high
    add(0, 0, 1, 1, 0, 1, 0, 16'h0000, 4'd0);
    add(0, 0, 1, 1, 0, 1, 0, 16'h0000, 4'd0);
    // LSB-first A5C3 with the consumer ready; out_valid drops a cycle later
    add_word(16'hA5C3, 1, 16'h0000);
    add(1, 0, 0, 0, 1, 1, 0, 16'hA5C3, 4'd0);
    // 1234 left pending, then 15 bits of FFFF: stall on the last bit
    add_word(16'h1234, 0, 16'hA5C3);
    add_bits(16'hFFFF, 15, 1, 16'h1234);
    add(1, 0, 1, 1, 0, 0, 1, 16'h1234, 4'd15);   // stalled, nothing accepted
    add(1, 0, 1, 1, 1, 1, 0, 16'h1234, 4'd15);   // take: slot frees, bit still held off
    add(1, 0, 1, 1, 0, 1, 1, 16'hFFFF, 4'd0);    // 16th bit accepted
    add(1, 0, 0, 0, 1, 1, 0, 16'hFFFF, 4'd0);    // drain
    // Flush mid-word with a valid 1 presented, then 8001
    add_bits(16'h00FF, 7, 0, 16'hFFFF);
    add(1, 1, 1, 1, 0, 1, 0, 16'hFFFF, 4'd0);
    add_word(16'h8001, 0, 16'hFFFF);
    // Flush coinciding with an output take: both happen
    add_bits(16'h0007, 3, 1, 16'h8001);
    add(1, 1, 1, 1, 1, 1, 0, 16'h8001, 4'd0);
    // Reset mid-operation: 0F0F pending and fill=9
    add_word(16'h0F0F, 0, 16'h8001);
    add_bits(16'h01FF, 9, 1, 16'h0F0F);
    add(0, 1, 1, 1, 1, 1, 0, 16'h0000, 4'd0);
    add_word(16'h3C5A, 0, 16'h0000);

    // Inputs change only after the #1 that follows each posedge
    tick();
    foreach (vecs[k]) begin
      reset = vecs[k].rst; flush = vecs[k].fl; in_valid = vecs[k].iv;
      in_bit = vecs[k].ib; out_ready = vecs[k].ordy;
      tick();
      chk($sformatf("v%0d.in_ready", k),  32'(in_ready),  32'(vecs[k].e_rdy));
      chk($sformatf("v%0d.out_valid", k), 32'(out_valid), 32'(vecs[k].e_ov));
      chk($sformatf("v%0d.out_data", k),  32'(out_data),  32'(vecs[k].e_od));
      chk($sformatf("v%0d.fill", k),      32'(fill),      32'(vecs[k].e_fill));
    end

    // MSB-first BEEF with random idle gaps
    m_in_valid = 1; m_in_bit = 1;
    tick();
    chk("msb.reset.out_valid", 32'(m_out_valid), 32'd0);
    chk("msb.reset.out_data",  32'(m_out_data),  32'd0);
    chk("msb.reset.fill",      32'(m_fill),      32'd0);
    m_reset = 1;
    begin
      logic [15:0] w;
      w = 16'hBEEF;
      for (int i = 15; i >= 0; i--) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          m_in_valid = 0; m_in_bit = 1'($urandom);
          tick();
          chk("msb.gap.fill", 32'(m_fill), 32'(15 - i));
        end
        m_in_valid = 1; m_in_bit = w[i];
        tick();
        chk("msb.acc.fill", 32'(m_fill), 32'((16 - i) % 16));
        chk("msb.acc.out_valid", 32'(m_out_valid), 32'(i == 0));
      end
      m_in_valid = 0;
      chk("msb.out_data", 32'(m_out_data), 32'h0000BEEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
